// File: rtl/alu_bcd_display_seq.sv
// Sequential ALU with a shift-add-3 BCD converter and registered 7-segment outputs.
// One operation per opsel edge; the display is refreshed whenever the inputs or the operation change.
module alu_bcd_display_seq #(
    parameter int Bits = 5,
    parameter int NDIG = 2,
    parameter int NOPS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                opsel,
    input  logic [Bits-1:0]     vA,
    input  logic [Bits-1:0]     vB,
    output logic [NOPS-1:0]     operation,
    output logic [3:0]          ALUflags,
    output logic [NDIG*7-1:0]   digits,
    output logic [6:0]          minus,
    output logic                busy,
    output logic                valid
);

    typedef enum logic [1:0] {IDLE, CALC, CONV, DONE} state_t;

    localparam int CW = $clog2(Bits + 1);
    localparam int M = Bits - 1;
    localparam logic [2:0] OPMAX = 3'(NOPS - 1);

    state_t state, nxt;

    logic [2:0]        op, lop;
    logic              opsel_q;
    logic              pending;
    logic [Bits-1:0]   la, lb, bin;
    logic [NDIG*4-1:0] bcd, adj;
    logic [CW-1:0]     cnt;
    logic [3:0]        fl, fcomb;
    logic              neg, neg_c;
    logic              start, conv_last;
    logic [Bits-1:0]   res, mag;
    logic [Bits:0]     sum, dif;
    logic              c, v;
    logic [NDIG*7-1:0] seg_o;
    logic              lead;
    logic [3:0]        dg;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Operation select advances in every state, one step per rising edge of opsel
    always_ff @(posedge clk) begin
        if (rst) begin
            op      <= '0;
            opsel_q <= 1'b0;
        end else begin
            opsel_q <= opsel;
            if (opsel && !opsel_q)
                op <= (op == OPMAX) ? 3'd0 : op + 3'd1;
        end
    end

    assign operation = NOPS'(1) << op;
    assign busy      = (state != IDLE);
    assign start     = (state == IDLE) &&
                       (pending || ({vA, vB, op} != {la, lb, lop}));
    assign conv_last = (cnt == CW'(Bits - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:    if (start) nxt = CALC;
            CALC:    nxt = CONV;
            CONV:    if (conv_last) nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        sum = {1'b0, la} + {1'b0, lb};
        dif = {1'b0, la} - {1'b0, lb};
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (lop)
            3'd0: begin
                res = sum[Bits-1:0];
                c   = sum[Bits];
                v   = (la[M] == lb[M]) && (res[M] != la[M]);
            end
            3'd1: begin
                res = dif[Bits-1:0];
                c   = ~dif[Bits];
                v   = (la[M] != lb[M]) && (res[M] != la[M]);
            end
            3'd2: res = la & lb;
            3'd3: res = la | lb;
            3'd4: res = la ^ lb;
            3'd5: begin
                res = {la[Bits-2:0], 1'b0};
                c   = la[M];
            end
            3'd6: begin
                res = {1'b0, la[Bits-1:1]};
                c   = la[0];
            end
            3'd7: begin
                res = {la[M], la[Bits-1:1]};
                c   = la[0];
            end
            default: res = '0;
        endcase
        fcomb = {res[M], res == '0, c, v};
        neg_c = (lop <= 3'd1) && res[M];
        // Two's complement of the most negative value reads back as 2**(Bits-1) unsigned
        mag   = neg_c ? (~res + 1'b1) : res;
    end

    always_comb begin
        adj = bcd;
        for (int i = 0; i < NDIG; i++)
            if (adj[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end

    always_comb begin
        seg_o = '1;
        lead  = 1'b1;
        dg    = '0;
        for (int i = NDIG - 1; i >= 0; i--) begin
            dg = bcd[i*4 +: 4];
            if (lead && dg == 4'd0 && i != 0) begin
                seg_o[i*7 +: 7] = 7'h7F;
            end else begin
                seg_o[i*7 +: 7] = seg7(dg);
                lead = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= 1'b1;
            la       <= '0;
            lb       <= '0;
            lop      <= '0;
            bin      <= '0;
            bcd      <= '0;
            cnt      <= '0;
            fl       <= '0;
            neg      <= 1'b0;
            ALUflags <= '0;
            digits   <= '1;
            minus    <= 7'h7F;
            valid    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        la      <= vA;
                        lb      <= vB;
                        lop     <= op;
                        pending <= 1'b0;
                    end
                end
                CALC: begin
                    fl  <= fcomb;
                    neg <= neg_c;
                    bin <= mag;
                    bcd <= '0;
                    cnt <= '0;
                end
                CONV: begin
                    bcd <= {adj[NDIG*4-2:0], bin[Bits-1]};
                    bin <= {bin[Bits-2:0], 1'b0};
                    cnt <= cnt + CW'(1);
                end
                DONE: begin
                    ALUflags <= fl;
                    digits   <= seg_o;
                    minus    <= neg ? 7'h3F : 7'h7F;
                    valid    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_bcd_display_seq.sv
// Bench for alu_bcd_display_seq: directed scenarios plus randomized
// operands checked against an integer-arithmetic reference model.
module tb_alu_bcd_display_seq;

    localparam int B  = 5;
    localparam int ND = 2;
    localparam int NO = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            opsel = 1'b0;
    logic [B-1:0]    va = '0;
    logic [B-1:0]    vb = '0;
    logic [NO-1:0]   operation;
    logic [3:0]      ALUflags;
    logic [ND*7-1:0] digits;
    logic [6:0]      minus;
    logic            busy;
    logic            valid;

    int tests = 0;
    int fails = 0;
    int mop   = 0;

    logic [6:0] segtab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    alu_bcd_display_seq #(.Bits(B), .NDIG(ND), .NOPS(NO)) dut (
        .clk(clk), .rst(rst), .opsel(opsel), .vA(va), .vB(vb),
        .operation(operation), .ALUflags(ALUflags), .digits(digits),
        .minus(minus), .busy(busy), .valid(valid)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic settle();
        step(3 * (B + 2) + 4);
    endtask

    task automatic pulse();
        opsel = 1'b1;
        step(1);
        opsel = 1'b0;
        step(1);
        mop = (mop + 1) % NO;
    endtask

    task automatic measure(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (busy) cyc++;
            else if (cyc > 0) break;
        end
    endtask

    function automatic void model(input int a, input int b, input int op,
                                  output logic [ND*7-1:0] dg,
                                  output logic [6:0] mn,
                                  output logic [3:0] fl);
        int M = 1 << B;
        int H = 1 << (B - 1);
        int sa, sb, r, s, mg, p;
        bit c, v, n, neg;
        sa = (a >= H) ? a - M : a;
        sb = (b >= H) ? b - M : b;
        c = 0; v = 0; r = 0;
        case (op)
            0: begin r = (a + b) % M; c = (a + b) >= M; s = sa + sb; v = (s > H - 1) || (s < -H); end
            1: begin r = (a - b + M) % M; c = a >= b; s = sa - sb; v = (s > H - 1) || (s < -H); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = (a * 2) % M; c = a >= H; end
            6: begin r = a / 2; c = (a % 2) == 1; end
            default: begin r = ((sa - (a % 2)) / 2 + M) % M; c = (a % 2) == 1; end
        endcase
        n   = r >= H;
        neg = (op < 2) && n;
        mg  = neg ? M - r : r;
        fl  = {n, r == 0, c, v};
        mn  = neg ? 7'h3F : 7'h7F;
        p   = 1;
        dg  = '1;
        for (int d = 0; d < ND; d++) begin
            if (d > 0 && mg < p) dg[d*7 +: 7] = 7'h7F;
            else                 dg[d*7 +: 7] = segtab[(mg / p) % 10];
            p = p * 10;
        end
    endfunction

    task automatic test_reset();
        rst = 1'b1; va = '0; vb = '0; opsel = 1'b0;
        step(2);
        tests++;
        if ({digits, minus, ALUflags} !== {14'h3FFF, 7'h7F, 4'h0}) begin
            fails++;
            $display("FAIL reset_disp: got %h/%h/%b expected 3fff/7f/0000", digits, minus, ALUflags);
        end
        tests++;
        if ({busy, valid, operation} !== {1'b0, 1'b0, 4'b0001}) begin
            fails++;
            $display("FAIL reset_ctl: got busy=%b valid=%b op=%b expected 0 0 0001", busy, valid, operation);
        end
        rst = 1'b0;
        mop = 0;
        step(7);
        tests++;
        if (busy !== 1'b1 || valid !== 1'b0 || digits !== 14'h3FFF) begin
            fails++;
            $display("FAIL reset_latency: got busy=%b valid=%b digits=%h expected 1 0 3fff", busy, valid, digits);
        end
        step(1);
        tests++;
        if ({digits, minus, ALUflags, valid, busy} !== {7'h7F, 7'h40, 7'h7F, 4'b0100, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL reset_first: got %h/%h/%b v=%b b=%b expected 3fc0/7f/0100 v=1 b=0",
                     digits, minus, ALUflags, valid, busy);
        end
    endtask

    task automatic test_add();
        int cyc;
        va = 5'd5; vb = 5'd6;
        measure(cyc);
        tests++;
        if (cyc !== 7) begin
            fails++;
            $display("FAIL add_busy: got %0d cycles expected 7", cyc);
        end
        tests++;
        if ({digits, minus, ALUflags} !== {7'h79, 7'h79, 7'h7F, 4'b0000}) begin
            fails++;
            $display("FAIL add_disp: got %h/%h/%b expected 3cf9/7f/0000", digits, minus, ALUflags);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        va = 5'd15; vb = 5'd1;
        measure(cyc);
        tests++;
        if (cyc !== 7) begin
            fails++;
            $display("FAIL ovf_busy: got %0d cycles expected 7", cyc);
        end
        tests++;
        if ({digits, minus, ALUflags} !== {7'h79, 7'h02, 7'h3F, 4'b1001}) begin
            fails++;
            $display("FAIL ovf_disp: got %h/%h/%b expected 3c82/3f/1001", digits, minus, ALUflags);
        end
    endtask

    task automatic test_sub();
        pulse();
        va = 5'd3; vb = 5'd9;
        settle();
        tests++;
        if ({busy, operation} !== {1'b0, 4'b0010}) begin
            fails++;
            $display("FAIL sub_ctl: got busy=%b op=%b expected 0 0010", busy, operation);
        end
        tests++;
        if ({digits, minus, ALUflags} !== {7'h7F, 7'h02, 7'h3F, 4'b1000}) begin
            fails++;
            $display("FAIL sub_disp: got %h/%h/%b expected 3f82/3f/1000", digits, minus, ALUflags);
        end
    endtask

    task automatic test_opsel();
        opsel = 1'b1;
        step(10);
        mop = (mop + 1) % NO;
        tests++;
        if (operation !== 4'(1 << mop)) begin
            fails++;
            $display("FAIL opsel_held: got %b expected %b", operation, 4'(1 << mop));
        end
        opsel = 1'b0;
        step(1);
        for (int k = 0; k < 3; k++) begin
            pulse();
            tests++;
            if (operation !== 4'(1 << mop)) begin
                fails++;
                $display("FAIL opsel_pulse%0d: got %b expected %b", k, operation, 4'(1 << mop));
            end
        end
        settle();
    endtask

    task automatic test_midconv();
        logic [ND*7-1:0] ed;
        logic [6:0] em;
        logic [3:0] ef;
        va = 5'($urandom);
        vb = 5'($urandom);
        step(4);
        vb = vb + 5'd1;
        settle();
        model(va, vb, mop, ed, em, ef);
        tests++;
        if ({busy, digits, minus, ALUflags} !== {1'b0, ed, em, ef}) begin
            fails++;
            $display("FAIL midconv_final: got %h/%h/%b expected %h/%h/%b", digits, minus, ALUflags, ed, em, ef);
        end
        va = va + 5'd3;
        step(4);
        rst = 1'b1;
        step(1);
        tests++;
        if ({digits, minus, ALUflags, busy, valid, operation} !== {14'h3FFF, 7'h7F, 4'h0, 1'b0, 1'b0, 4'b0001}) begin
            fails++;
            $display("FAIL midconv_rst: got %h/%h/%b b=%b v=%b op=%b expected blanks, idle, op 0001",
                     digits, minus, ALUflags, busy, valid, operation);
        end
        rst = 1'b0;
        mop = 0;
        settle();
        model(va, vb, mop, ed, em, ef);
        tests++;
        if ({valid, digits, minus, ALUflags} !== {1'b1, ed, em, ef}) begin
            fails++;
            $display("FAIL midconv_after: got %h/%h/%b expected %h/%h/%b", digits, minus, ALUflags, ed, em, ef);
        end
    endtask

    task automatic test_random();
        logic [ND*7-1:0] ed;
        logic [6:0] em;
        logic [3:0] ef;
        int n;
        for (int i = 0; i < 24; i++) begin
            n = $urandom_range(0, 2);
            for (int k = 0; k < n; k++) pulse();
            va = 5'($urandom);
            vb = 5'($urandom);
            settle();
            model(va, vb, mop, ed, em, ef);
            tests++;
            if ({busy, valid, operation, digits, minus, ALUflags} !==
                {1'b0, 1'b1, 4'(1 << mop), ed, em, ef}) begin
                fails++;
                $display("FAIL rand%0d a=%0d b=%0d op=%0d: got %b/%h/%h/%b expected %b/%h/%h/%b",
                         i, va, vb, mop, operation, digits, minus, ALUflags,
                         4'(1 << mop), ed, em, ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_overflow();
        test_sub();
        test_opsel();
        test_midconv();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
